log_mem_ctrl: RTL and testbench

Capture/readback controller for the 32-bit data-log RAM.
- The register file's one-cycle o_run_log pulse starts a capture: one RAM write per valid datapath sample until the RAM is full.
- Full status is then reported back for the IS_MEM_FULL command.
- Single-address reads requested by the register file's o_read_log/o_addr_log_to_mem are served, and the word is returned on i_data_log_from_mem.
- Sits between the register file, the Tx/Rx sample stream and a simple-dual-port BRAM.

---
 rtl/log_mem_pkg.sv | 15 +
 rtl/log_mem_ctrl_if.sv | 27 ++
 rtl/log_rd_pipe.sv | 53 +++++
 rtl/log_mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_log_mem_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/log_mem_pkg.sv
// Shared definitions for the data-log RAM controller: FSM state encoding,
// default bus widths and the supported RAM read-latency range.
package log_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2
  } log_state_e;

  localparam int NB_ADDR_MEM_DEF = 15;
  localparam int NB_DATA_DEF     = 32;
  localparam int RAM_RD_LAT_MAX  = 4;

endpackage

// File: rtl/log_mem_ctrl_if.sv
// Simple-dual-port BRAM bus between the log controller (master) and the
// log RAM (slave): one write port, one read port with registered data.
interface log_ram_if
  import log_mem_pkg::*;
#(
  parameter int NB_ADDR_MEM = NB_ADDR_MEM_DEF,
  parameter int NB_DATA     = NB_DATA_DEF
);

  logic                   wr_en;
  logic [NB_ADDR_MEM-1:0] wr_addr;
  logic [NB_DATA-1:0]     wr_data;
  logic                   rd_en;
  logic [NB_ADDR_MEM-1:0] rd_addr;
  logic [NB_DATA-1:0]     rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data
  );

endinterface

// File: rtl/log_rd_pipe.sv
// Read-return pipeline: a RAM_RD_LAT-deep valid shift register that tracks
// the single outstanding BRAM read and captures the returned word.
// A flush drops the read in flight so no response pulse is produced.
module log_rd_pipe
  import log_mem_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_DEF,
  parameter int RAM_RD_LAT = 2
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_launch,
  input  logic [NB_DATA-1:0] i_rd_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_vld,
  output logic               o_busy
);

  logic [RAM_RD_LAT-1:0] vld_sr;
  logic                  take;

  assign take   = vld_sr[RAM_RD_LAT-1] && !i_flush;
  assign o_busy = |vld_sr;

  // Advance the in-flight marker one stage per cycle; stage 0 lines up
  // with the cycle the BRAM sees its read enable.
  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= i_launch;
      for (int i = 1; i < RAM_RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  // Register the BRAM word when its marker reaches the last stage; the word
  // then holds until the next completed read.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_data <= '0;
      o_vld  <= 1'b0;
    end else begin
      o_vld <= take;
      if (take) begin
        o_data <= i_rd_data;
      end
    end
  end

endmodule

// File: rtl/log_mem_ctrl.sv
// Capture/readback controller for the data-log RAM.
// A run pulse starts a capture that writes one word per accepted sample
// until all 2**NB_ADDR_MEM addresses are filled, then reports full and
// serves single-word reads.
// Optional build macro LOG_DECIM_EN: write only every (i_decim+1)-th valid
// sample during a capture.
module log_mem_ctrl
  import log_mem_pkg::*;
#(
  parameter int NB_ADDR_MEM = NB_ADDR_MEM_DEF,
  parameter int NB_DATA     = NB_DATA_DEF,
  parameter int RAM_RD_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_run_log,
  input  logic                   i_read_log,
  input  logic [NB_ADDR_MEM-1:0] i_addr_log,
  input  logic [NB_DATA-1:0]     i_data,
  input  logic                   i_valid,
  input  logic [7:0]             i_decim,
  log_ram_if.master              ram,
  output logic [NB_DATA-1:0]     o_data_log,
  output logic                   o_data_log_vld,
  output logic                   o_mem_full,
  output logic                   o_busy
);

  log_state_e state_q, state_d;

  // Extra MSB marks "all addresses written", so the counter never wraps.
  logic [NB_ADDR_MEM:0]   cnt_q;
  logic                   wr_en_q;
  logic [NB_ADDR_MEM-1:0] wr_addr_q;
  logic [NB_DATA-1:0]     wr_data_q;
  logic                   rd_en_q;
  logic [NB_ADDR_MEM-1:0] rd_addr_q;

  logic smp;
  logic wr_acc;
  logic rd_acc;
  logic decim_ok;
  logic rd_busy;

`ifdef LOG_DECIM_EN
  logic [7:0] decim_q;
  logic [7:0] dcnt_q;

  // Decimation phase: ratio latched at run, phase 0 marks a sample to keep.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      decim_q <= 8'd0;
      dcnt_q  <= 8'd0;
    end else if (i_run_log) begin
      decim_q <= i_decim;
      dcnt_q  <= 8'd0;
    end else if (smp) begin
      dcnt_q <= (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
    end
  end

  assign decim_ok = (dcnt_q == 8'd0);
`else
  logic unused_decim;
  assign unused_decim = ^i_decim;
  assign decim_ok     = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus sample/read acceptance; a run pulse overrides everything.
  always_comb begin
    state_d = state_q;
    smp     = 1'b0;
    wr_acc  = 1'b0;
    rd_acc  = 1'b0;
    if (i_run_log) begin
      state_d = ST_CAPTURE;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          smp    = i_valid && !cnt_q[NB_ADDR_MEM];
          wr_acc = smp && decim_ok;
          if (wr_en_q && (wr_addr_q == '1)) begin
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          rd_acc = i_read_log && !rd_busy;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Write path: one registered BRAM write per accepted sample.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wr_acc;
      if (i_run_log) begin
        cnt_q <= '0;
      end else if (wr_acc) begin
        cnt_q     <= cnt_q + (NB_ADDR_MEM+1)'(1);
        wr_addr_q <= cnt_q[NB_ADDR_MEM-1:0];
        wr_data_q <= i_data;
      end
    end
  end

  // Read launch: one-cycle enable, address held between reads.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      rd_en_q <= rd_acc;
      if (rd_acc) begin
        rd_addr_q <= i_addr_log;
      end
    end
  end

  log_rd_pipe #(
    .NB_DATA    (NB_DATA),
    .RAM_RD_LAT (RAM_RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_flush   (i_run_log),
    .i_launch  (rd_acc),
    .i_rd_data (ram.rd_data),
    .o_data    (o_data_log),
    .o_vld     (o_data_log_vld),
    .o_busy    (rd_busy)
  );

  assign ram.wr_en   = wr_en_q;
  assign ram.wr_addr = wr_addr_q;
  assign ram.wr_data = wr_data_q;
  assign ram.rd_en   = rd_en_q;
  assign ram.rd_addr = rd_addr_q;

  assign o_mem_full = (state_q == ST_FULL);
  assign o_busy     = (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_log_mem_ctrl.sv
// Directed bench for log_mem_ctrl with a 16-word behavioural BRAM.
module tb_log_mem_ctrl;
  import log_mem_pkg::*;

  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_run_log = 1'b0;
  logic          i_read_log = 1'b0;
  logic [AW-1:0] i_addr_log = '0;
  logic [DW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic [7:0]    i_decim = 8'd0;
  logic [DW-1:0] o_data_log;
  logic          o_data_log_vld;
  logic          o_mem_full;
  logic          o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  log_ram_if #(.NB_ADDR_MEM(AW), .NB_DATA(DW)) ram_if ();

  log_mem_ctrl #(.NB_ADDR_MEM(AW), .NB_DATA(DW), .RAM_RD_LAT(LAT)) dut (
    .clk            (clk),
    .i_rst          (i_rst),
    .i_run_log      (i_run_log),
    .i_read_log     (i_read_log),
    .i_addr_log     (i_addr_log),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .i_decim        (i_decim),
    .ram            (ram_if),
    .o_data_log     (o_data_log),
    .o_data_log_vld (o_data_log_vld),
    .o_mem_full     (o_mem_full),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  // BRAM: write port plus one registered read stage; together with the
  // controller's enable flop that gives a two-stage read path.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_if.wr_en) mem[ram_if.wr_addr] <= ram_if.wr_data;
    if (ram_if.rd_en) ram_if.rd_data <= mem[ram_if.rd_addr];
  end

  // Event log sampled on the falling edge.
  int          nw = 0, nrd = 0, nvld = 0;
  logic [31:0] wa [256];
  logic [31:0] wd [256];
  always @(negedge clk) begin
    if (ram_if.wr_en && nw < 256) begin
      wa[nw] = 32'(ram_if.wr_addr);
      wd[nw] = ram_if.wr_data;
    end
    if (ram_if.wr_en) nw++;
    if (ram_if.rd_en) nrd++;
    if (o_data_log_vld) nvld++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pulse();
    i_run_log = 1'b1;
    tick();
    i_run_log = 1'b0;
  endtask

  // Feed samples base+k until full (or budget expires); toggle drives
  // i_valid only on even k.
  task automatic capture(input logic [31:0] base, input bit toggle);
    int k;
    k = 0;
    while (!o_mem_full && k < 200) begin
      i_valid = toggle ? (k % 2 == 0) : 1'b1;
      i_data  = base + 32'(k);
      tick();
      k++;
    end
    i_valid = 1'b0;
    chk("capture_done", 32'(o_mem_full), 32'd1);
  endtask

  task automatic chk_writes(input int b, input logic [31:0] base, input logic [31:0] stride);
    chk("write_count", 32'(nw - b), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("wr_addr[%0d]", i), wa[b+i], 32'(i));
      chk($sformatf("wr_data[%0d]", i), wd[b+i], base + stride * 32'(i));
    end
  endtask

  int b, r, v;

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_wr_en", 32'(ram_if.wr_en), 0);
    chk("rst_rd_en", 32'(ram_if.rd_en), 0);
    chk("rst_full", 32'(o_mem_full), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_vld", 32'(o_data_log_vld), 0);
    i_rst = 1'b0;
    // i_valid in IDLE is ignored
    i_valid = 1'b1; i_data = 32'hDEAD;
    b = nw;
    repeat (3) tick();
    i_valid = 1'b0;
    tick();
    chk("idle_no_write", 32'(nw - b), 0);

    // Toggling valid: 16 contiguous writes of the even-k samples
    b = nw;
    run_pulse();
    capture(32'h200, 1'b1);
    repeat (3) tick();
    chk_writes(b, 32'h200, 32'd2);

    // Continuous valid with exact full timing
    b = nw;
    run_pulse();
    chk("run_busy", 32'(o_busy), 1);
    chk("run_full", 32'(o_mem_full), 0);
    for (int n = 0; n < 16; n++) begin
      i_valid = 1'b1; i_data = 32'h100 + 32'(n);
      tick();
    end
    chk("last_wr_addr", 32'(ram_if.wr_addr), 32'd15);
    chk("last_wr_full", 32'(o_mem_full), 0);
    i_data = 32'h1FF;
    tick();
    chk("full_rise", 32'(o_mem_full), 1);
    chk("busy_fall", 32'(o_busy), 0);
    chk("no_wr_in_full", 32'(ram_if.wr_en), 0);
    repeat (3) tick();
    i_valid = 1'b0;
    chk_writes(b, 32'h100, 32'd1);

    // Read addr 7, second request at +1 dropped
    r = nrd; v = nvld;
    i_read_log = 1'b1; i_addr_log = 4'd7;
    tick();
    chk("rd_en_p1", 32'(ram_if.rd_en), 1);
    chk("rd_addr_p1", 32'(ram_if.rd_addr), 32'd7);
    i_addr_log = 4'd3;
    tick();
    i_read_log = 1'b0;
    chk("rd_en_p2", 32'(ram_if.rd_en), 0);
    chk("vld_p2", 32'(o_data_log_vld), 0);
    tick();
    chk("vld_p3", 32'(o_data_log_vld), 1);
    chk("data_p3", o_data_log, 32'h107);
    tick();
    chk("vld_p4", 32'(o_data_log_vld), 0);
    chk("data_hold", o_data_log, 32'h107);
    repeat (3) tick();
    chk("rd_en_count", 32'(nrd - r), 1);
    chk("vld_count", 32'(nvld - v), 1);
    i_read_log = 1'b1; i_addr_log = 4'd15;
    tick();
    i_read_log = 1'b0;
    repeat (4) tick();
    chk("data_addr15", o_data_log, 32'h10F);
    chk("rd_addr_hold", 32'(ram_if.rd_addr), 32'd15);

    // Flushed read, read during capture, read simultaneous with run
    r = nrd; v = nvld;
    i_read_log = 1'b1; i_addr_log = 4'd5;
    tick();
    i_read_log = 1'b0;
    run_pulse();
    b = nw;
    i_valid = 1'b1; i_data = 32'h300;
    tick();
    i_read_log = 1'b1; i_data = 32'h301;
    tick();
    i_read_log = 1'b0;
    capture(32'h302, 1'b0);
    repeat (2) tick();
    chk_writes(b, 32'h300, 32'd1);
    b = nw;
    i_run_log = 1'b1; i_read_log = 1'b1; i_addr_log = 4'd9;
    tick();
    i_run_log = 1'b0; i_read_log = 1'b0;
    chk("run_wins_busy", 32'(o_busy), 1);
    capture(32'h600, 1'b0);
    repeat (4) tick();
    chk("run_wins_writes", 32'(nw - b), 32'd16);
    chk("cap_rd_en_count", 32'(nrd - r), 1);
    chk("cap_vld_count", 32'(nvld - v), 0);
    chk("cap_data_hold", o_data_log, 32'h10F);

    // Reset mid-capture, then restart from address 0
    b = nw;
    run_pulse();
    for (int n = 0; n < 5; n++) begin
      i_valid = 1'b1; i_data = 32'h400 + 32'(n);
      tick();
    end
    chk("pre_rst_addr", 32'(ram_if.wr_addr), 32'd4);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0; i_valid = 1'b0;
    chk("mid_rst_wr_en", 32'(ram_if.wr_en), 0);
    chk("mid_rst_wr_addr", 32'(ram_if.wr_addr), 0);
    chk("mid_rst_wr_data", ram_if.wr_data, 0);
    chk("mid_rst_rd_addr", 32'(ram_if.rd_addr), 0);
    chk("mid_rst_data_log", o_data_log, 0);
    chk("mid_rst_busy", 32'(o_busy), 0);
    chk("mid_rst_full", 32'(o_mem_full), 0);
    chk("mid_rst_writes", 32'(nw - b), 32'd5);
    b = nw;
    run_pulse();
    capture(32'h500, 1'b0);
    repeat (2) tick();
    chk_writes(b, 32'h500, 32'd1);

`ifdef LOG_DECIM_EN
    // Decimation by 3: keep samples 0,3,6,...
    b = nw;
    i_decim = 8'd2;
    run_pulse();
    i_decim = 8'd0;
    capture(32'h0, 1'b0);
    repeat (2) tick();
    chk_writes(b, 32'h0, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
